// File: rtl/rr_arb_lock.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_lock
// Purpose  : Registered round-robin arbiter with transaction locking for the
//            PIM request path. The search starts at a rotating pointer and
//            moves upward with wrap-around at N_REQ-1. Once a requester is
//            granted, the grant is held until one of three things happens:
//            the owner presents its last beat, the owner drops its request,
//            or the owner reaches the beat budget. Re-arbitration happens in
//            the same cycle as completion, so handover needs no idle cycle.
//            Every output comes straight from a flop.
// Ports    : clk        - clock, rising edge
//            rst_n      - asynchronous active-low reset
//            req        - per-requester request (level)
//            req_last   - per-requester final-beat marker (owner's bit only)
//            gnt_ready  - downstream accepts the current beat
//            gnt_valid  - grant active
//            gnt_idx    - owner index, stable while gnt_valid
//            gnt_onehot - one-hot of gnt_idx qualified by gnt_valid
//            abort      - one-cycle pulse: owner dropped req before last beat
//            preempt    - one-cycle pulse: forced release at MAX_BEATS
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_lock #(
    parameter int N_REQ     = 16,
    parameter int MAX_BEATS = 0,
    // Derived; leave at its default.
    parameter int IDX_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_last,
    input  logic             gnt_ready,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic             abort,
    output logic             preempt
);

    localparam int          BCNT_W   = 8;
    localparam logic [0:0]  ST_ARB   = 1'b0;
    localparam logic [0:0]  ST_GRANT = 1'b1;

    // ------------------------------------------------------------------------
    // Round-robin search. Returns {found, index}. The index is walked as
    // ptr, ptr+1, ... and folded back at N_REQ so that a non-power-of-two
    // requester count never produces an index beyond N_REQ-1.
    // ------------------------------------------------------------------------
    function automatic logic [IDX_W:0] pick(input logic [IDX_W-1:0] ptr,
                                            input logic [N_REQ-1:0] vec);
        logic             hit;
        logic [IDX_W-1:0] sel;
        int               j;
        hit = 1'b0;
        sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!hit && vec[j]) begin
                hit = 1'b1;
                sel = j[IDX_W-1:0];
            end
        end
        return {hit, sel};
    endfunction

    logic [0:0]        state_q,   state_d;
    logic [IDX_W-1:0]  ptr_q,     ptr_d;
    logic [IDX_W-1:0]  idx_q,     idx_d;
    logic              valid_q,   valid_d;
    logic [N_REQ-1:0]  onehot_q,  onehot_d;
    logic [BCNT_W-1:0] cnt_q,     cnt_d;
    logic              abort_q,   abort_d;
    logic              preempt_q, preempt_d;

    logic              w_owner_req;
    logic              w_owner_last;
    logic              w_beat;
    logic [BCNT_W:0]   w_cnt_inc;
    logic              w_budget_hit;
    logic              w_done_norm;
    logic              w_done_pre;
    logic              w_done_abort;
    logic [IDX_W-1:0]  w_next_start;
    logic [IDX_W:0]    w_pick_arb;
    logic [IDX_W:0]    w_pick_rel;

    assign w_owner_req  = req[idx_q];
    assign w_owner_last = req_last[idx_q];
    assign w_beat       = valid_q && gnt_ready && w_owner_req;
    assign w_cnt_inc    = {1'b0, cnt_q} + {{BCNT_W{1'b0}}, 1'b1};
    // Budget is checked against the count this beat would produce.
    assign w_budget_hit = (MAX_BEATS != 0) && (w_cnt_inc == (BCNT_W+1)'(MAX_BEATS));
    // A last beat wins over the budget, so preempt only fires without last.
    assign w_done_norm  = w_beat && w_owner_last;
    assign w_done_pre   = w_beat && !w_owner_last && w_budget_hit;
    assign w_done_abort = !w_owner_req;
    assign w_next_start = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
    assign w_pick_arb   = pick(ptr_q, req);
    // Starting after the owner makes the owner lowest priority, yet it can
    // still win when it is the only requester left.
    assign w_pick_rel   = pick(w_next_start, req);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ARB;
            ptr_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            onehot_q  <= '0;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            onehot_q  <= onehot_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            preempt_q <= preempt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        abort_d   = 1'b0;
        preempt_d = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (w_pick_arb[IDX_W]) begin
                    state_d = ST_GRANT;
                    idx_d   = w_pick_arb[IDX_W-1:0];
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (w_done_norm || w_done_pre || w_done_abort) begin
                    ptr_d     = w_next_start;
                    abort_d   = w_done_abort;
                    preempt_d = w_done_pre;
                    cnt_d     = '0;
                    if (w_pick_rel[IDX_W]) begin
                        idx_d   = w_pick_rel[IDX_W-1:0];
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_ARB;
                        valid_d = 1'b0;
                    end
                end else if (w_beat) begin
                    // Saturate so an unlimited budget never wraps the count.
                    cnt_d = (cnt_q == {BCNT_W{1'b1}}) ? cnt_q : w_cnt_inc[BCNT_W-1:0];
                end
            end
            default: begin
                state_d = ST_ARB;
                valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: decode the next grant so the one-hot is also a flop.
    // ------------------------------------------------------------------------
    always_comb begin
        onehot_d = '0;
        if (valid_d) begin
            onehot_d[idx_d] = 1'b1;
        end
    end

    assign gnt_valid  = valid_q;
    assign gnt_idx    = idx_q;
    assign gnt_onehot = onehot_q;
    assign abort      = abort_q;
    assign preempt    = preempt_q;

endmodule
`default_nettype wire

// File: doc/rr_arb_lock.md
# rr_arb_lock

Parametrised, registered round-robin arbiter with transaction locking for the PIM request path. Picks one of `N_REQ` requesters starting at a rotating pointer and searching upward with wrap-around. Holds the grant across multi-beat transactions until the owner signals its last beat, drops, or exceeds a beat budget. All outputs are registered, so the block can sit between request queues and a shared downstream port without adding combinational depth.

## Interface
- `N_REQ`, 16, number of requesters; legal range 2..64; need not be a power of two.
- `MAX_BEATS`, 0, beat budget per grant; 0 means unlimited, otherwise 1..255.
- `IDX_W`, derived: `$clog2(N_REQ)`, width of index and pointer.
- `BCNT_W`, derived: 8, width of the beat counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in N_REQ: per-requester request, level.
- `req_last` in N_REQ: per-requester final-beat marker; sampled only for the current owner.
- `gnt_ready` in 1: downstream accepts the current beat.
- `gnt_valid` out 1: grant active.
- `gnt_idx` out IDX_W: owner index; stable while `gnt_valid`.
- `gnt_onehot` out N_REQ: one-hot of `gnt_idx` qualified by `gnt_valid`.
- `abort` out 1: one-cycle pulse when the owner drops `req` before its last beat.
- `preempt` out 1: one-cycle pulse on forced release at `MAX_BEATS`.

## Operation
- **Reset.** Async assert forces: state ARB, `rr_ptr`=0, `beat_cnt`=0, `gnt_valid`=0, `gnt_idx`=0, `gnt_onehot`=0, `abort`=0, `preempt`=0.
- **Search function.** `pick(ptr, vec)` returns the first set bit at index ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1. Wrap is at `N_REQ-1`, not at 2^IDX_W. It also returns `found`=|vec.
- **State ARB** (`gnt_valid`=0).
  - If |req: register `gnt_idx`=pick(`rr_ptr`, req), set `gnt_valid`=1, set `beat_cnt`=0, go to GRANT.
  - Otherwise stay in ARB.
- **State GRANT.**
  - A beat is `gnt_valid && gnt_ready && req[gnt_idx]`; each beat increments `beat_cnt`.
  - **Completion:**
    - Normal: a beat with `req_last[gnt_idx]`=1.
    - Abort: `req[gnt_idx]`=0 in GRANT; `abort` pulses.
    - Preempt: a beat that makes `beat_cnt`==MAX_BEATS without last, with MAX_BEATS≠0; `preempt` pulses.
  - **On completion:**
    - `rr_ptr` <= (gnt_idx+1) mod N_REQ.
    - Same-cycle re-arbitration with pick((gnt_idx+1) mod N_REQ, req).
    - If found: stay in GRANT with the new `gnt_idx`, `beat_cnt`=0, `gnt_valid` stays 1 (zero-bubble handover).
    - Else: go to ARB with `gnt_valid`=0.
  - The previous owner may win again if it is the only requester; it is lowest priority otherwise.
  - Otherwise hold: `gnt_idx`, `gnt_valid` and `rr_ptr` are unchanged. `req` changes of non-owners are ignored.
- **Boundary rules.**
  - `gnt_ready`=0: no beat, no count, grant held indefinitely.
  - Last beat and budget reached in the same cycle: normal completion, no `preempt`.
  - Abort and beat cannot coincide, because a beat requires `req[gnt_idx]`=1.
  - `req_last` of non-owners is ignored.
  - With MAX_BEATS=0 the counter saturates at 255 and never triggers preempt.
  - Reset asserted mid-transaction drops the grant immediately. After release the first grant searches from index 0.

## Timing
- Request to grant: 1 cycle. `req` is sampled at edge k in ARB, and `gnt_valid`/`gnt_idx` are visible after edge k.
- Back-to-back handover: the new owner is visible the cycle after the completing beat. Single-beat requesters with `gnt_ready`=1 get one grant per cycle.
- `abort` and `preempt` are registered. Each is high for exactly the cycle following the triggering edge.
- There is no combinational path from any input to any output.

## Test plan
- **Reset and single request.** Hold `rst_n`=0: all outputs 0. Release, then `req`=0x0010 → next cycle `gnt_valid`=1, `gnt_idx`=4, `gnt_onehot`=0x0010.
- **Full rotation.** N_REQ=16, `req`=0xFFFF, `req_last`=0xFFFF, `gnt_ready`=1 → `gnt_idx` sequence 0,1,…,15,0 on consecutive cycles, no bubbles.
- **Non-power-of-two wrap.** N_REQ=5, owner 3 completes, then `req`=5'b00101 → next `gnt_idx`=0 (search order 4,0), never 5–7.
- **Lock with backpressure.** Owner 2 issues 3 beats with `gnt_ready` toggling 1,0,1,0,1 and `req_last` on the third beat, while `req[7]`=1 → `gnt_idx`=2 for 5 cycles, then 7.
- **Preempt.** MAX_BEATS=4, owner 1 streams without last, requester 9 waiting → after the 4th beat `preempt` pulses once, and `gnt_idx`=9 next cycle.
- **Abort and reset mid-transaction.** Owner 6 drops `req` after 1 beat, with no other requester → `abort` pulses, `gnt_valid`=0, `rr_ptr`=7. Re-grant, then assert `rst_n`=0 mid-grant → outputs clear asynchronously.
